pack_arb_2ch: RTL
=================

PACK_ARB_2CH -- requirements
Module: pack_arb_2ch

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, the number of idle cycles in HI before a forced flush (used only with PACK_TIMEOUT_EN).
REQ-002 The block SHALL have parameter PAD, default 8'h00, the low-byte fill value for a flushed word.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have ports s0_valid, input, 1 bit and s0_data, input, 8 bits: the channel-0 byte stream.
REQ-006 The block SHALL have port s0_ready, output, 1 bit: the channel-0 byte is accepted when s0_valid and s0_ready are both high.
REQ-007 The block SHALL have ports s1_valid, input, 1; s1_data, input, 8; and s1_ready, output, 1: the same channel-1 stream and handshake.
REQ-008 The block SHALL have ports m_valid, output, 1 bit and m_data, output, 16 bits: the packed output word.
REQ-009 The block SHALL have port m_src, output, 1 bit: the channel that produced m_data.
REQ-010 The block SHALL have port m_pad, output, 1 bit: high when the low byte of m_data is PAD from a flush.
REQ-011 The block SHALL have port m_ready, input, 1 bit: the word is consumed when m_valid and m_ready are both high.

Function
REQ-012 The block SHALL arbitrate one shared 8-to-16 packer between two byte channels, granting at whole-word granularity.
REQ-013 The block SHALL implement the FSM states IDLE (no grant), HI (high byte captured, waiting for low byte) and OUT (word held on m_*).
REQ-014 In IDLE, the block SHALL grant by round-robin among valid channels: the channel not granted last wins a tie; after reset, ch0 wins a tie.
REQ-015 In IDLE, ready SHALL be high only for the granted channel (combinational on s*_valid), and its byte SHALL be captured into m_data[15:8] with the FSM moving to HI.
REQ-016 In HI, ready SHALL be high only for the granted channel; its byte SHALL go to m_data[7:0] and the FSM SHALL move to OUT.
REQ-017 The grant SHALL be held from IDLE through OUT; the other channel's ready SHALL stay low even if it is valid.
REQ-018 Latency SHALL be one cycle: a low byte accepted at edge N gives m_valid=1 after edge N.
REQ-019 In OUT, the block SHALL hold m_valid=1 and keep m_data, m_src and m_pad stable until m_ready; both s*_ready SHALL be 0 throughout OUT.
REQ-020 On the m_valid&&m_ready edge, the FSM SHALL go to IDLE, m_valid SHALL drop to 0 and the round-robin pointer SHALL update to m_src.
REQ-021 A word SHALL never mix bytes from two channels, and no byte SHALL be dropped or duplicated.

Reset
REQ-022 While rst=1 at a clock edge, the block SHALL set the state to IDLE, m_valid=0, m_data=16'h0000, m_src=0, m_pad=0, round-robin to favour ch0, and clear the timeout counter.
REQ-023 While rst=1, both s*_ready SHALL be 0.
REQ-024 A reset in HI or OUT SHALL discard the partial or pending word, and the first cycle after reset SHALL behave as IDLE.

Configuration
REQ-025 With macro PACK_TIMEOUT_EN defined, a counter SHALL run in HI; if it reaches TIMEOUT cycles with no low byte, the block SHALL go to OUT with m_data[7:0]=PAD and m_pad=1.
REQ-026 With PACK_TIMEOUT_EN defined, the counter SHALL clear on entry to HI and on every accepted byte.
REQ-027 Without PACK_TIMEOUT_EN, HI SHALL wait indefinitely, m_pad SHALL be tied to 0, and no counter logic SHALL exist.

Verification
REQ-028 The bench SHALL cover: ch0 sends 45, AB; m_ready=1 -> m_data=45AB, m_src=0, m_valid one cycle after the AB accept.
REQ-029 The bench SHALL cover: both channels continuously valid (ch0 11,22,33,44; ch1 AA,BB,CC,DD) -> words 1122(0), AABB(1), 3344(0), CCDD(1).
REQ-030 The bench SHALL cover: m_ready=0 for 5 cycles in OUT with word F238 -> m_data stable, both s*_ready=0, word emitted once when m_ready=1.
REQ-031 The bench SHALL cover: ch0 sends 12, then ch1 sends 99 while ch0 is idle in HI -> s1_ready=0 until ch0's word completes.
REQ-032 The bench SHALL cover: rst pulsed in HI after byte 7E -> all outputs at reset values, and the next pair 01,02 gives 0102.
REQ-033 The bench SHALL cover, with PACK_TIMEOUT_EN: ch1 sends 5C, then nothing for 15 cycles -> m_data=5C00, m_pad=1, m_src=1.

Source files
------------

// File: rtl/pack_arb_2ch.sv
// rtl/pack_arb_2ch.sv - two-channel byte arbiter feeding one shared 8-to-16 packer
// Optional forced flush of a half-filled word is enabled by defining PACK_TIMEOUT_EN.

module pack_arb_2ch #(
   parameter int         TIMEOUT = 15,
   parameter logic [7:0] PAD     = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s0_valid,
   input  logic [7:0]  s0_data,
   output logic        s0_ready,
   input  logic        s1_valid,
   input  logic [7:0]  s1_data,
   output logic        s1_ready,
   output logic        m_valid,
   output logic [15:0] m_data,
   output logic        m_src,
   output logic        m_pad,
   input  logic        m_ready
);

   typedef enum logic [1:0] {S_IDLE, S_HI, S_OUT} state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_src;
   logic        r_last;
   logic [15:0] r_data;
   logic        w_pick;
   logic        w_sel_valid;
   logic        w_take;
   logic        w_flush;
   logic [7:0]  w_byte;

`ifdef PACK_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CW-1:0] r_cnt;
   logic          r_pad;

   assign w_flush = (r_state == S_HI) && !w_sel_valid && (r_cnt == CW'(TIMEOUT - 1));
   assign m_pad   = r_pad;
`else
   logic w_unused_cfg;

   assign w_unused_cfg = ^{PAD, TIMEOUT};
   assign w_flush      = 1'b0;
   assign m_pad        = 1'b0;
`endif

   // The grant is chosen in IDLE and then frozen in r_src until the word is consumed.
   assign w_pick      = (r_state != S_IDLE) ? r_src :
                        (s0_valid && s1_valid) ? ~r_last : s1_valid;
   assign w_sel_valid = w_pick ? s1_valid : s0_valid;
   assign w_byte      = w_pick ? s1_data : s0_data;
   assign w_take      = (s0_ready & s0_valid) | (s1_ready & s1_valid);

   assign m_valid = (r_state == S_OUT);
   assign m_data  = r_data;
   assign m_src   = r_src;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      s0_ready = 1'b0;
      s1_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_sel_valid && !rst) begin
               s0_ready = ~w_pick;
               s1_ready = w_pick;
               w_next   = S_HI;
            end
         end
         S_HI: begin
            s0_ready = ~w_pick & ~rst;
            s1_ready = w_pick & ~rst;
            if (w_sel_valid || w_flush) begin
               w_next = S_OUT;
            end
         end
         S_OUT: begin
            if (m_ready) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data <= 16'h0000;
         r_src  <= 1'b0;
         r_last <= 1'b1;
`ifdef PACK_TIMEOUT_EN
         r_cnt  <= '0;
         r_pad  <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_take) begin
                  r_data[15:8] <= w_byte;
                  r_src        <= w_pick;
`ifdef PACK_TIMEOUT_EN
                  r_cnt        <= '0;
                  r_pad        <= 1'b0;
`endif
               end
            end
            S_HI: begin
               if (w_take) begin
                  r_data[7:0] <= w_byte;
`ifdef PACK_TIMEOUT_EN
                  r_cnt       <= '0;
               end else if (w_flush) begin
                  r_data[7:0] <= PAD;
                  r_pad       <= 1'b1;
               end else begin
                  r_cnt       <= r_cnt + 1'b1;
`endif
               end
            end
            S_OUT: begin
               // Remember who was served so the other channel wins the next tie.
               if (m_ready) begin
                  r_last <= r_src;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
